// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes, flag bit positions
// and the default program-counter width.
package cpu_pkg;

  localparam int CPU_PC_W = 16;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    BR_NE,
    BR_EQ,
    BR_GT,
    BR_LT,
    BR_GE,
    BR_LE,
    BR_OV,
    BR_UNCOND
  } br_cond_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational condition-code test of a branch against the {z,v,n}
// flag vector.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] flag,
  input  logic [2:0] cond,
  output logic       taken
);

  logic z;
  logic v;
  logic n;

  assign z = flag[FLAG_Z];
  assign v = flag[FLAG_V];
  assign n = flag[FLAG_N];

  always_comb begin
    taken = 1'b0;
    unique case (br_cond_t'(cond))
      BR_NE:     taken = ~z;
      BR_EQ:     taken = z;
      BR_GT:     taken = ~z & ~n;
      BR_LT:     taken = n;
      BR_GE:     taken = z | ~n;
      BR_LE:     taken = z | n;
      BR_OV:     taken = v;
      BR_UNCOND: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Conditional-branch resolver: stalls on pending flag writes, then emits
// a registered resolve pulse with taken/next-PC. Optional BRANCH_STATS_EN.
module branch_resolve
  import cpu_pkg::*;
#(
  parameter int PC_W  = CPU_PC_W,
  parameter int OFF_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       flag,
  input  logic             ex_flag_wr,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [OFF_W-1:0] br_off,
  input  logic             kill,
  output logic             res_valid,
  output logic             res_taken,
  output logic [PC_W-1:0]  res_pc,
  output logic             flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]      stat_total,
  output logic [15:0]      stat_taken
`endif
);

  typedef enum logic {
    IDLE,
    WAIT_FLAG
  } state_t;

  state_t           state_q;
  logic [2:0]       cond_q;
  logic [PC_W-1:0]  pc_q;
  logic [OFF_W-1:0] off_q;
  logic             res_valid_q;
  logic             res_taken_q;
  logic [PC_W-1:0]  res_pc_q;
  logic             flush_q;

  logic             in_wait;
  logic             hs;
  logic             fire;
  logic [2:0]       ev_cond;
  logic [PC_W-1:0]  ev_pc;
  logic [OFF_W-1:0] ev_off;
  logic [PC_W-1:0]  ev_sext;
  logic [PC_W-1:0]  ev_fall;
  logic [PC_W-1:0]  ev_tgt;
  logic             ev_taken;

  assign in_wait  = (state_q == WAIT_FLAG);
  assign br_ready = ~in_wait;
  assign hs       = br_valid & br_ready;

  // A stalled request has priority; IDLE evaluates the live request.
  assign ev_cond = in_wait ? cond_q : br_cond;
  assign ev_pc   = in_wait ? pc_q   : br_pc;
  assign ev_off  = in_wait ? off_q  : br_off;

  assign ev_sext = {{(PC_W-OFF_W){ev_off[OFF_W-1]}}, ev_off};
  assign ev_fall = ev_pc + PC_W'(1);
  assign ev_tgt  = ev_fall + ev_sext;

  assign fire = ~kill & ~ex_flag_wr & (in_wait | hs);

  branch_cond u_cond (
    .flag  (flag),
    .cond  (ev_cond),
    .taken (ev_taken)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cond_q      <= '0;
      pc_q        <= '0;
      off_q       <= '0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      res_pc_q    <= '0;
      flush_q     <= 1'b0;
    end else begin
      res_valid_q <= fire;
      flush_q     <= fire & ev_taken;
      if (fire) begin
        res_taken_q <= ev_taken;
        res_pc_q    <= ev_taken ? ev_tgt : ev_fall;
      end
      if (kill) begin
        state_q <= IDLE;
        cond_q  <= '0;
        pc_q    <= '0;
        off_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (hs && ex_flag_wr) begin
              state_q <= WAIT_FLAG;
              cond_q  <= br_cond;
              pc_q    <= br_pc;
              off_q   <= br_off;
            end
          end
          WAIT_FLAG: begin
            if (!ex_flag_wr) state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_taken = res_taken_q;
  assign res_pc    = res_pc_q;
  assign flush     = flush_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] tot_q;
  logic [15:0] tkn_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tot_q <= '0;
      tkn_q <= '0;
    end else if (fire) begin
      if (tot_q != 16'hFFFF) tot_q <= tot_q + 16'd1;
      if (ev_taken && tkn_q != 16'hFFFF) tkn_q <= tkn_q + 16'd1;
    end
  end

  assign stat_total = tot_q;
  assign stat_taken = tkn_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: random and directed requests
// against a protocol-level reference model.
module tb_branch_resolve;

  logic        clk;
  logic        rst;
  logic [2:0]  flag;
  logic        ex_flag_wr;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_cond;
  logic [15:0] br_pc;
  logic [8:0]  br_off;
  logic        kill;
  logic        res_valid;
  logic        res_taken;
  logic [15:0] res_pc;
  logic        flush;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_total;
  logic [15:0] stat_taken;
`endif

  branch_resolve dut (
    .clk        (clk),
    .rst        (rst),
    .flag       (flag),
    .ex_flag_wr (ex_flag_wr),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_cond    (br_cond),
    .br_pc      (br_pc),
    .br_off     (br_off),
    .kill       (kill),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .res_pc     (res_pc),
    .flush      (flush)
`ifdef BRANCH_STATS_EN
    ,
    .stat_total (stat_total),
    .stat_taken (stat_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [2:0]  c;
    bit [15:0] pc;
    bit [8:0]  off;
  } req_t;

  typedef struct {
    bit        taken;
    bit [15:0] pc;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   pending = 0;
  req_t held;
  bit   last_taken = 0;
  bit [15:0] last_pc = 0;
  int   m_total = 0;
  int   m_taken = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic bit ref_taken(input bit [2:0] c, input bit [2:0] f);
    bit z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic exp_t ref_resolve(input req_t r, input bit [2:0] f);
    exp_t e;
    int   off;
    int   nxt;
    off = (r.off >= 256) ? int'(r.off) - 512 : int'(r.off);
    e.taken = ref_taken(r.c, f);
    nxt = int'(r.pc) + 1 + (e.taken ? off : 0);
    nxt = ((nxt % 65536) + 65536) % 65536;
    e.pc = nxt[15:0];
    return e;
  endfunction

  // Monitor: outputs reflect the previous rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      last_taken = 0;
      last_pc = 0;
      m_total = 0;
      m_taken = 0;
    end else begin
      chk("flush", flush, res_valid & res_taken);
      if (res_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_res_valid", res_valid, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("res_taken", res_taken, e.taken);
          chk("res_pc", res_pc, e.pc);
          if (m_total < 65535) m_total++;
          if (e.taken && m_taken < 65535) m_taken++;
        end
        last_taken = res_taken;
        last_pc = res_pc;
      end else begin
        if (sbq.size() != 0) begin
          chk("missing_res_valid", res_valid, 1);
          void'(sbq.pop_front());
        end
        chk("hold_taken", res_taken, last_taken);
        chk("hold_pc", res_pc, last_pc);
      end
`ifdef BRANCH_STATS_EN
      chk("stat_total", stat_total, m_total);
      chk("stat_taken", stat_taken, m_taken);
`endif
    end
  end

  task automatic step(input bit v, input bit [2:0] c, input bit [15:0] pc,
                      input bit [8:0] off, input bit ew, input bit k,
                      input bit [2:0] f);
    req_t r;
    @(negedge clk);
    #1;
    chk("br_ready", br_ready, !pending);
    br_valid = v;
    br_cond = c;
    br_pc = pc;
    br_off = off;
    ex_flag_wr = ew;
    kill = k;
    flag = f;
    r.c = c;
    r.pc = pc;
    r.off = off;
    if (k) begin
      pending = 0;
    end else if (pending) begin
      if (!ew) begin
        sbq.push_back(ref_resolve(held, f));
        pending = 0;
      end
    end else if (v) begin
      if (!ew) sbq.push_back(ref_resolve(r, f));
      else begin
        held = r;
        pending = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 3'b000);
  endtask

  initial begin
    rst = 1'b0;
    flag = '0;
    ex_flag_wr = 0;
    br_valid = 0;
    br_cond = '0;
    br_pc = '0;
    br_off = '0;
    kill = 0;
    #12;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_taken", res_taken, 0);
    chk("rst_res_pc", res_pc, 0);
    chk("rst_flush", flush, 0);
    chk("rst_br_ready", br_ready, 1);
    #1 rst = 1'b1;
    idle(1);

    step(1, 3'd1, 16'h0010, 9'd5, 0, 0, 3'b100);
    step(1, 3'd4, 16'h0020, 9'h1FD, 0, 0, 3'b001);
    idle(1);
    // Flag hazard across two writer cycles.
    step(1, 3'd0, 16'h0100, 9'd8, 1, 0, 3'b100);
    step(0, 3'd0, 16'h0000, 9'd0, 1, 0, 3'b100);
    step(0, 3'd0, 16'h0000, 9'd0, 0, 0, 3'b000);
    idle(1);
    step(1, 3'd7, 16'hFFFE, 9'd4, 0, 0, 3'b000);
    idle(1);
    step(1, 3'd2, 16'h0200, 9'd3, 1, 0, 3'b000);
    step(0, 3'd0, 16'h0000, 9'd0, 1, 1, 3'b000);
    step(1, 3'd6, 16'h0300, 9'h1F0, 0, 0, 3'b010);
    idle(1);
    step(1, 3'd3, 16'h0400, 9'd1, 0, 0, 3'b001);
    step(1, 3'd5, 16'h0401, 9'd2, 0, 0, 3'b000);
    step(1, 3'd6, 16'h0402, 9'd3, 0, 0, 3'b010);
    idle(2);

    // Async reset mid-WAIT_FLAG drops the request.
    step(1, 3'd7, 16'h0500, 9'd7, 1, 0, 3'b000);
    @(negedge clk);
    #2;
    rst = 1'b0;
    sbq.delete();
    pending = 0;
    ex_flag_wr = 0;
    br_valid = 0;
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_br_ready", br_ready, 1);
    chk("midrst_res_pc", res_pc, 0);
    @(negedge clk);
    #3 rst = 1'b1;
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      bit [15:0] pc;
      pc = ($urandom % 8 == 0) ? 16'hFFF8 | 16'($urandom % 8)
                               : 16'($urandom);
      step($urandom % 4 != 0, 3'($urandom), pc, 9'($urandom),
           $urandom % 3 == 0, $urandom % 16 == 0, 3'($urandom));
    end
    idle(3);
    chk("drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
